// File: rtl/spi_slave_io_modes.sv
// SPI register-access slave: a command word (2-bit opcode + start address) followed by data words, SPI modes 0-3.
// Optional feature: define SPI_SLAVE_BURST_EN to auto-increment reg_addr after every completed data word.
module spi_slave_io_modes #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          sclk,
    input  logic          nreset,
    input  logic          ss,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic          spi_en,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          lsbfirst,
    output logic [AW-1:0] reg_addr,
    output logic          reg_write,
    output logic          reg_read,
    output logic [DW-1:0] reg_wdata,
    input  logic [DW-1:0] reg_rdata,
    output logic [7:0]    word_count
);
    localparam int CW   = AW + 2;
    localparam int MAXW = (CW > DW) ? CW : DW;
    localparam int BW   = $clog2(MAXW);
    localparam logic [BW-1:0] CMD_LAST  = BW'(CW - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    // Sample edge is always posedge clk_s, launch edge is always negedge clk_s.
    logic clk_s;
    logic arst_n;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cmd_q, cmd_d, cmd_full;
    logic [DW-1:0] rx_q, rx_d, rx_full;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          load_q, load_d;
    logic [DW-1:0] tx_q, tx_d;
    logic          armed_q;
    logic          cmd_done, word_done;

    assign clk_s  = sclk ^ cpol ^ cpha;
    assign arst_n = nreset & ~ss;

    always_comb begin
        cmd_full  = lsbfirst ? {mosi, cmd_q[CW-1:1]} : {cmd_q[CW-2:0], mosi};
        rx_full   = lsbfirst ? {mosi, rx_q[DW-1:1]}  : {rx_q[DW-2:0], mosi};
        cmd_done  = (state_q == CMD)  && (bit_cnt_q == CMD_LAST);
        word_done = (state_q == DATA) && (bit_cnt_q == DATA_LAST);

        reg_write = spi_en && word_done && (op_q == OP_WRITE);
        reg_read  = spi_en && ((cmd_done && (cmd_full[CW-1:CW-2] == OP_READ)) ||
                               (word_done && (op_q == OP_READ)));
        reg_wdata = rx_full;

        // A read strobe must already present the address being fetched, before addr_q catches up.
        reg_addr = addr_q;
        if (cmd_done) begin
            reg_addr = cmd_full[AW-1:0];
        end
`ifdef SPI_SLAVE_BURST_EN
        else if (word_done && (op_q == OP_READ)) begin
            reg_addr = addr_q + AW'(1);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wcnt_d    = wcnt_q;
        load_d    = reg_read;
        unique case (state_q)
            IDLE: begin
                // The entry edge already captures command bit 0.
                if (spi_en && armed_q) begin
                    state_d   = CMD;
                    cmd_d     = cmd_full;
                    bit_cnt_d = BW'(1);
                end
            end
            CMD: begin
                cmd_d = cmd_full;
                if (cmd_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    op_d      = cmd_full[CW-1:CW-2];
                    addr_d    = cmd_full[AW-1:0];
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            DATA: begin
                rx_d = rx_full;
                if (word_done) begin
                    bit_cnt_d = '0;
                    wcnt_d    = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
`ifdef SPI_SLAVE_BURST_EN
                    addr_d    = addr_q + AW'(1);
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_s or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            op_q      <= '0;
            wcnt_q    <= '0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            op_q      <= op_d;
            wcnt_q    <= wcnt_d;
            load_q    <= load_d;
        end
    end

    // The address survives ss rising so the last accessed register stays visible.
    always_ff @(posedge clk_s or negedge nreset) begin
        if (!nreset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    always_comb begin
        if (load_q) begin
            tx_d = reg_rdata;
        end else if (lsbfirst) begin
            tx_d = tx_q >> 1;
        end else begin
            tx_d = tx_q << 1;
        end
    end

    always_ff @(negedge clk_s or negedge nreset) begin
        if (!nreset) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    // After a reset, only a fresh ss falling edge re-enables the slave.
    always_ff @(negedge ss or negedge nreset) begin
        if (!nreset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign miso       = lsbfirst ? tx_q[0] : tx_q[DW-1];
    assign miso_oe    = ~ss & spi_en & (state_q == DATA) & (op_q == OP_READ);
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_spi_slave_io_modes.sv
// Scoreboard bench for spi_slave_io_modes: expected strobes are queued by the stimulus and popped by a monitor.
module tb_spi_slave_io_modes;
    localparam int AW = 6;
    localparam int DW = 8;
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          sclk, nreset, ss, mosi, miso, miso_oe;
    logic          spi_en, cpol, cpha, lsbfirst;
    logic [AW-1:0] reg_addr;
    logic          reg_write, reg_read;
    logic [DW-1:0] reg_wdata, reg_rdata;
    logic [7:0]    word_count;

    spi_slave_io_modes #(.AW(AW), .DW(DW)) dut (
        .sclk(sclk), .nreset(nreset), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .spi_en(spi_en), .cpol(cpol), .cpha(cpha), .lsbfirst(lsbfirst),
        .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .word_count(word_count)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] miso_cap, oe_cap;
    event        probe_ev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Monitor: every strobe seen just before a sample edge must match the head of the queue.
    always begin
        @(probe_ev);
        if (reg_write || reg_read) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {reg_write, reg_read}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind", {reg_write, reg_read}, {mon_e.wr, ~mon_e.wr});
                chk("strobe_addr", reg_addr, mon_e.addr);
                if (mon_e.wr) chk("strobe_wdata", reg_wdata, mon_e.data);
            end
        end
    end

    task automatic set_mode(input logic [1:0] m, input logic lsb);
        cpol     = m[1];
        cpha     = m[0];
        lsbfirst = lsb;
        sclk     = m[1];
        #20;
    endtask

    // Sends vec[n-1] first; probes DUT outputs 1 ns before each sample edge.
    task automatic spi_bits(input logic [63:0] vec, input int n);
        miso_cap = '0;
        oe_cap   = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (cpha) begin
                sclk = ~sclk;
                mosi = vec[i];
            end else begin
                mosi = vec[i];
            end
            #9;
            -> probe_ev;
            miso_cap = {miso_cap[62:0], miso};
            oe_cap   = {oe_cap[62:0], miso_oe};
            #1;
            sclk = ~sclk;
            #10;
            if (!cpha) sclk = ~sclk;
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        #10;
    endtask

    task automatic ss_high();
        #10;
        ss = 1'b1;
        #20;
    endtask

    initial begin
        nreset = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; spi_en = 1'b1;
        cpol = 1'b0; cpha = 1'b0; lsbfirst = 1'b0; reg_rdata = '0;
        #25;
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_reg_read", reg_read, 1'b0);
        chk("rst_word_count", word_count, 8'd0);
        chk("rst_reg_addr", reg_addr, 6'd0);
        nreset = 1'b1;
        #20;

        // Mode 0 single write.
        set_mode(2'd0, 1'b0);
        push(1'b1, 6'h05, 8'hA5);
        ss_low(); spi_bits({8'h05, 8'hA5}, 16);
        chk("m0_write_wcount", word_count, 8'd1);
        ss_high();

        // Mode 3 read of 0x3C.
        set_mode(2'd3, 1'b0);
        reg_rdata = 8'h3C;
        push(1'b0, 6'h03, 8'h00);
        push(1'b0, BURST ? 6'h04 : 6'h03, 8'h00);
        ss_low(); spi_bits({8'h83, 8'h00}, 16);
        chk("m3_read_miso", miso_cap[7:0], 8'h3C);
        chk("m3_read_oe", oe_cap[15:0], 16'h00FF);
        chk("m3_read_wcount", word_count, 8'd1);
        ss_high();
        chk("m3_oe_after_ss", miso_oe, 1'b0);

        // Three-word write at the top address.
        set_mode(2'd0, 1'b0);
        push(1'b1, 6'h3F, 8'h11);
        push(1'b1, BURST ? 6'h00 : 6'h3F, 8'h22);
        push(1'b1, BURST ? 6'h01 : 6'h3F, 8'h33);
        ss_low(); spi_bits({8'h3F, 8'h11, 8'h22, 8'h33}, 32);
        chk("burst_wcount", word_count, 8'd3);
        ss_high();
        chk("wcount_clear_on_ss", word_count, 8'd0);

        // LSB-first writes in modes 1 and 2.
        set_mode(2'd1, 1'b1);
        push(1'b1, 6'h0A, 8'h80);
        ss_low(); spi_bits({rev8(8'h0A), 8'h01}, 16);
        chk("m1_lsb_wcount", word_count, 8'd1);
        ss_high();
        set_mode(2'd2, 1'b1);
        push(1'b1, 6'h21, 8'h80);
        ss_low(); spi_bits({rev8(8'h21), 8'h01}, 16);
        chk("m2_lsb_wcount", word_count, 8'd1);
        ss_high();

        // LSB-first read: 0x0F leaves the slave as 1,1,1,1,0,0,0,0.
        set_mode(2'd0, 1'b1);
        reg_rdata = 8'h0F;
        push(1'b0, 6'h04, 8'h00);
        push(1'b0, BURST ? 6'h05 : 6'h04, 8'h00);
        ss_low(); spi_bits({rev8(8'h84), 8'h00}, 16);
        chk("m0_lsb_read_miso", miso_cap[7:0], 8'hF0);
        ss_high();

        // Partial word: ss rises after 5 data bits.
        set_mode(2'd0, 1'b0);
        ss_low(); spi_bits({8'h07, 5'b10101}, 13);
        chk("partial_wcount", word_count, 8'd0);
        ss_high();
        chk("partial_wcount_after", word_count, 8'd0);
        chk("partial_oe_after", miso_oe, 1'b0);

        // Block disabled: no strobes, nothing counted.
        spi_en = 1'b0;
        ss_low(); spi_bits({8'h09, 8'hFF}, 16);
        chk("disabled_wcount", word_count, 8'd0);
        chk("disabled_oe", oe_cap[15:0], 16'h0000);
        ss_high();
        spi_en = 1'b1;

        // Reset pulse in the middle of a read data word.
        set_mode(2'd3, 1'b0);
        reg_rdata = 8'hFF;
        push(1'b0, 6'h03, 8'h00);
        ss_low(); spi_bits({8'h83, 4'h0}, 12);
        chk("pre_reset_oe", miso_oe, 1'b1);
        nreset = 1'b0;
        #5;
        chk("midrst_miso", miso, 1'b0);
        chk("midrst_miso_oe", miso_oe, 1'b0);
        chk("midrst_reg_write", reg_write, 1'b0);
        chk("midrst_reg_read", reg_read, 1'b0);
        chk("midrst_word_count", word_count, 8'd0);
        chk("midrst_reg_addr", reg_addr, 6'd0);
        #5;
        nreset = 1'b1;
        #10;
        // ss still low: the slave must stay idle until a new ss falling edge.
        spi_bits({8'h01, 8'hFF}, 16);
        chk("no_rearm_wcount", word_count, 8'd0);
        chk("no_rearm_oe", oe_cap[15:0], 16'h0000);
        ss_high();
        set_mode(2'd0, 1'b0);
        push(1'b1, 6'h12, 8'h5A);
        ss_low(); spi_bits({8'h12, 8'h5A}, 16);
        chk("post_rst_wcount", word_count, 8'd1);
        ss_high();

        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
